// File: rtl/prbs_checker_if.sv
// prbs_checker_if - bundle of the serial receive and status signals of the PRBS checker.
//
// Signals:
//   enable     master->slave  rxBit is valid this cycle
//   rxBit      master->slave  received serial bit
//   clear      master->slave  synchronous clear of err_count / lost_count
//   locked     slave->master  checker is in CHECK
//   err        slave->master  one-cycle pulse per mismatched bit
//   err_count  slave->master  saturating mismatch count (ERR_W bits)
//   lost_count slave->master  saturating lock-loss count (LOST_W bits)
//   zero_flag  slave->master  stuck-at-zero indicator (0 unless zero detect is built in)
//
// master = stream source / status consumer, slave = the checker.
interface prbs_checker_if #(
    parameter int ERR_W  = 16,
    parameter int LOST_W = 8
) ();
    logic              enable;
    logic              rxBit;
    logic              clear;
    logic              locked;
    logic              err;
    logic [ERR_W-1:0]  err_count;
    logic [LOST_W-1:0] lost_count;
    logic              zero_flag;

    modport master (
        output enable, rxBit, clear,
        input  locked, err, err_count, lost_count, zero_flag
    );

    modport slave (
        input  enable, rxBit, clear,
        output locked, err, err_count, lost_count, zero_flag
    );
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker - self-seeding receive checker for the Fibonacci LFSR stream
// s[n] = s[n-LEN] ^ s[n-LEN+TAP].
//
// The first LEN enabled bits fill the history (SEED). After that every
// received bit is compared with the bit predicted from the history (CHECK).
// The received bit always enters the history, so one flipped bit shows up as
// three mismatches. LOSS_THRESH consecutive mismatches drop back to SEED.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous reset, active low
//   bus    prbs_checker_if.slave (enable, rxBit, clear in; locked, err,
//          err_count, lost_count, zero_flag out)
//
// Optional feature: define PRBS_CHECK_ZERO_DET_EN to build the stuck-at-zero
// detector driving zero_flag; otherwise zero_flag is tied to 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_SEED  | filling history with LEN received bits, no comparisons
// ST_CHECK | locked; each enabled bit is compared with the prediction
module prbs_checker #(
    parameter int LEN         = 127,
    parameter int TAP         = 126,
    parameter int ERR_W       = 16,
    parameter int LOST_W      = 8,
    parameter int LOSS_THRESH = 8
) (
    input  logic          clk,
    input  logic          reset,
    prbs_checker_if.slave bus
);

    localparam int SEED_W = $clog2(LEN);

    localparam logic [0:0] ST_SEED  = 1'b0;
    localparam logic [0:0] ST_CHECK = 1'b1;

    localparam logic [SEED_W-1:0] SEED_LAST   = SEED_W'(LEN - 1);
    localparam logic [7:0]        CONSEC_LAST = 8'(LOSS_THRESH - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX     = '1;
    localparam logic [LOST_W-1:0] LOST_MAX    = '1;

    logic [0:0]        state;
    logic [LEN-1:0]    hist;        // hist[0] = newest bit, hist[LEN-1] = s[n-LEN]
    logic [SEED_W-1:0] seed_cnt;
    logic [7:0]        consec_cnt;
    logic              err_q;
    logic [ERR_W-1:0]  err_cnt;
    logic [LOST_W-1:0] lost_cnt;

    logic           pred;
    logic [LEN-1:0] hist_next;
    logic           mismatch;
    logic           seed_done;
    logic           lock_loss;

    // Prediction uses the history before this bit is shifted in.
    assign pred      = hist[LEN-1] ^ hist[LEN-1-TAP];
    assign hist_next = {hist[LEN-2:0], bus.rxBit};
    assign mismatch  = bus.enable && (state == ST_CHECK) && (bus.rxBit ^ pred);
    assign seed_done = bus.enable && (state == ST_SEED) && (seed_cnt == SEED_LAST);
    assign lock_loss = mismatch && (consec_cnt == CONSEC_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_SEED;
            hist       <= '0;
            seed_cnt   <= '0;
            consec_cnt <= '0;
            err_q      <= 1'b0;
            err_cnt    <= '0;
            lost_cnt   <= '0;
        end else begin
            err_q <= mismatch;

            if (bus.enable) begin
                hist <= hist_next;
                if (state == ST_SEED) begin
                    if (seed_done) begin
                        seed_cnt <= '0;
                        state    <= ST_CHECK;
                    end else begin
                        seed_cnt <= seed_cnt + 1'b1;
                    end
                end else if (lock_loss) begin
                    state      <= ST_SEED;
                    seed_cnt   <= '0;
                    consec_cnt <= '0;
                end else if (mismatch) begin
                    consec_cnt <= consec_cnt + 1'b1;
                end else begin
                    consec_cnt <= '0;
                end
            end

            // clear takes priority over a simultaneous increment
            if (bus.clear) begin
                err_cnt  <= '0;
                lost_cnt <= '0;
            end else begin
                if (mismatch && (err_cnt != ERR_MAX)) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (lock_loss && (lost_cnt != LOST_MAX)) begin
                    lost_cnt <= lost_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.locked     = (state == ST_CHECK);
    assign bus.err        = err_q;
    assign bus.err_count  = err_cnt;
    assign bus.lost_count = lost_cnt;

`ifdef PRBS_CHECK_ZERO_DET_EN
    logic zero_q;

    // Flag is judged against the post-edge lock state, so a stream of LEN
    // zeros raises it on the same edge that enters CHECK.
    always_ff @(posedge clk) begin
        if (!reset) begin
            zero_q <= 1'b0;
        end else if (bus.enable) begin
            if (bus.rxBit || lock_loss) begin
                zero_q <= 1'b0;
            end else if (((state == ST_CHECK) || seed_done) && (hist_next == '0)) begin
                zero_q <= 1'b1;
            end
        end
    end

    assign bus.zero_flag = zero_q;
`else
    assign bus.zero_flag = 1'b0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker - directed self-checking bench for prbs_checker.
// A default-parameter instance covers lock, error propagation, lock loss,
// gapped enable, clear and reset; a second instance (ERR_W=4,
// LOSS_THRESH=255) covers err_count saturation.
module tb_prbs_checker;

`ifdef PRBS_CHECK_ZERO_DET_EN
    localparam logic ZF_EXP = 1'b1;
`else
    localparam logic ZF_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_b = 1'b0;

    always #5 clk = ~clk;

    prbs_checker_if #(.ERR_W(16), .LOST_W(8)) u_if ();
    prbs_checker_if #(.ERR_W(4),  .LOST_W(8)) u_sat_if ();

    prbs_checker #(
        .LEN(127), .TAP(126), .ERR_W(16), .LOST_W(8), .LOSS_THRESH(8)
    ) u_dut (
        .clk   (clk),
        .reset (rst_b),
        .bus   (u_if)
    );

    prbs_checker #(
        .LEN(127), .TAP(126), .ERR_W(4), .LOST_W(8), .LOSS_THRESH(255)
    ) u_sat (
        .clk   (clk),
        .reset (rst_b),
        .bus   (u_sat_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [126:0] gen;       // reference generator, gen[0] newest
    logic [126:0] rx_hist;   // bits actually sent to the main instance
    int           bit_idx;
    int           err_pulses;
    int           err_pos[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic gen_bit(output logic b);
        b   = gen[126] ^ gen[0];
        gen = {gen[125:0], b};
    endtask

    function automatic logic rx_pred();
        return rx_hist[126] ^ rx_hist[0];
    endfunction

    // Drives one cycle on the main instance, samples 1 time unit after the edge.
    task automatic send(input logic b, input logic en = 1'b1, input logic clr = 1'b0);
        u_if.enable = en;
        u_if.rxBit  = b;
        u_if.clear  = clr;
        @(posedge clk);
        #1;
        if (en) begin
            rx_hist = {rx_hist[125:0], b};
            bit_idx++;
        end
        if (u_if.err) begin
            err_pulses++;
            err_pos.push_back(bit_idx);
        end
        u_if.enable = 1'b0;
        u_if.clear  = 1'b0;
    endtask

    task automatic send_gen(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            send(b);
        end
    endtask

    task automatic restart();
        rst_b = 1'b0;
        send(1'b0, 1'b0);
        rst_b      = 1'b1;
        rx_hist    = '0;
        bit_idx    = 0;
        err_pulses = 0;
        err_pos.delete();
        gen        = 127'h1;
    endtask

    initial begin
        logic b;
        int   exp_pos[3];

        exp_pos[0] = 500;
        exp_pos[1] = 501;
        exp_pos[2] = 627;

        u_if.enable = 1'b1;
        u_if.rxBit  = 1'b1;
        u_if.clear  = 1'b0;
        u_sat_if.enable = 1'b0;
        u_sat_if.rxBit  = 1'b0;
        u_sat_if.clear  = 1'b0;
        rx_hist    = '0;
        bit_idx    = 0;
        err_pulses = 0;
        gen        = 127'h1;

        // reset overrides enable
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_locked", u_if.locked, 0);
        check_val("rst_err", u_if.err, 0);
        check_val("rst_err_count", u_if.err_count, 0);
        check_val("rst_lost_count", u_if.lost_count, 0);
        check_val("rst_zero_flag", u_if.zero_flag, 0);
        u_if.enable = 1'b0;
        rst_b = 1'b1;

        // clean seeded stream
        for (int i = 1; i <= 1000; i++) begin
            gen_bit(b);
            send(b);
            if (i == 126) check_val("clean_locked_126", u_if.locked, 0);
            if (i == 127) check_val("clean_locked_127", u_if.locked, 1);
        end
        check_val("clean_pulses", err_pulses, 0);
        check_val("clean_err_count", u_if.err_count, 0);
        check_val("clean_lost_count", u_if.lost_count, 0);
        check_val("clean_locked", u_if.locked, 1);

        // single flipped bit at 500
        restart();
        for (int i = 1; i <= 1000; i++) begin
            gen_bit(b);
            if (i == 500) b = ~b;
            send(b);
        end
        check_val("flip_pulses", err_pulses, 3);
        for (int k = 0; k < 3; k++)
            check_val($sformatf("flip_pos%0d", k), (k < err_pos.size()) ? err_pos[k] : -1, exp_pos[k]);
        check_val("flip_err_count", u_if.err_count, 3);
        check_val("flip_locked", u_if.locked, 1);
        check_val("flip_lost_count", u_if.lost_count, 0);

        // clear alone leaves lock untouched
        send(1'b0, 1'b0, 1'b1);
        check_val("clr_err_count", u_if.err_count, 0);
        check_val("clr_locked", u_if.locked, 1);

        // loss of lock: 8 bits inverted from the prediction
        err_pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            send(~rx_pred());
            if (k == 7) begin
                check_val("loss_locked_7", u_if.locked, 1);
                check_val("loss_err_count_7", u_if.err_count, 7);
            end
        end
        check_val("loss_err_count", u_if.err_count, 8);
        check_val("loss_lost_count", u_if.lost_count, 1);
        check_val("loss_locked", u_if.locked, 0);
        check_val("loss_pulses", err_pulses, 8);
        send_gen(126);
        check_val("relock_126", u_if.locked, 0);
        send_gen(1);
        check_val("relock_127", u_if.locked, 1);
        send_gen(50);
        check_val("relock_err_count", u_if.err_count, 8);
        check_val("relock_pulses", err_pulses, 8);

        // gapped enable with garbage on idle cycles
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                gen_bit(b);
                send(b, 1'b1);
            end else begin
                send(1'($urandom_range(0, 1)), 1'b0);
            end
        end
        check_val("gap_err_count", u_if.err_count, 8);
        check_val("gap_pulses", err_pulses, 8);
        check_val("gap_locked", u_if.locked, 1);

        // clear coinciding with an error: pulse still seen, counts read 0
        send(~rx_pred(), 1'b1, 1'b1);
        check_val("clrerr_err", u_if.err, 1);
        check_val("clrerr_err_count", u_if.err_count, 0);
        check_val("clrerr_lost_count", u_if.lost_count, 0);
        send(1'b0, 1'b0);
        check_val("clrerr_err_next", u_if.err, 0);

        // reset mid-CHECK with enable high
        rst_b = 1'b0;
        send(1'b1, 1'b1, 1'b0);
        rst_b = 1'b1;
        rx_hist    = '0;
        bit_idx    = 0;
        err_pulses = 0;
        check_val("midrst_locked", u_if.locked, 0);
        check_val("midrst_err", u_if.err, 0);
        check_val("midrst_err_count", u_if.err_count, 0);
        check_val("midrst_lost_count", u_if.lost_count, 0);
        check_val("midrst_zero_flag", u_if.zero_flag, 0);
        send_gen(126);
        check_val("midrst_locked_126", u_if.locked, 0);
        send_gen(1);
        check_val("midrst_locked_127", u_if.locked, 1);
        send_gen(30);
        check_val("midrst_pulses", err_pulses, 0);

        // all-zero stream is a valid sequence
        restart();
        for (int i = 1; i <= 200; i++) begin
            send(1'b0);
            if (i == 127) begin
                check_val("zero_locked_127", u_if.locked, 1);
                check_val("zero_flag_127", u_if.zero_flag, ZF_EXP);
            end
        end
        check_val("zero_err_count", u_if.err_count, 0);
        check_val("zero_pulses", err_pulses, 0);
        check_val("zero_flag_end", u_if.zero_flag, ZF_EXP);

        // saturation: all ones mismatch every bit after seeding (1^1 = 0)
        restart();
        for (int i = 1; i <= 227; i++) begin
            u_sat_if.enable = 1'b1;
            u_sat_if.rxBit  = 1'b1;
            @(posedge clk);
            #1;
            if (i == 127) begin
                check_val("sat_locked_127", u_sat_if.locked, 1);
                check_val("sat_err_count_127", u_sat_if.err_count, 0);
            end
            if (i == 142) check_val("sat_err_count_15", u_sat_if.err_count, 15);
        end
        u_sat_if.enable = 1'b0;
        check_val("sat_err_count", u_sat_if.err_count, 15);
        check_val("sat_lost_count", u_sat_if.lost_count, 0);
        check_val("sat_locked", u_sat_if.locked, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side counterpart of the 127-stage Fibonacci LFSR sequence generator used in the CMAC/SPI test path.
- Takes the serial bit stream the generator emits, self-seeds its history from the first LEN bits, then predicts every following bit and compares it with the received bit.
- Reports lock, per-bit errors, saturating error and lock-loss counts.
- Sits at the far end of the serial link in the testbench/BIST path.

Parameters:
- LEN, 127, register length; the oldest tap is s[n-LEN].
- TAP, 126, second tap index; predicted s[n] = s[n-LEN] ^ s[n-LEN+TAP] (default gives s[n-127] ^ s[n-1]).
- ERR_W, 16, width of err_count.
- LOST_W, 8, width of lost_count.
- LOSS_THRESH, 8, consecutive mismatches that force re-seeding (range 1..255).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low; asserted when 0, sampled on the clk edge.
- enable  input  1  rxBit is valid this cycle; nothing advances when 0.
- rxBit  input  1  received serial bit, same ordering as the generator's newBit.
- clear  input  1  synchronous clear of err_count and lost_count.
- locked  output  1  high while in CHECK.
- err  output  1  one-cycle pulse per mismatched bit.
- err_count  output  ERR_W  saturating count of mismatches.
- lost_count  output  LOST_W  saturating count of CHECK->SEED transitions.
- zero_flag  output  1  stuck-at-zero indicator (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (reset==0 at the edge):
  - history = 0, state = SEED, seed counter = 0, consecutive counter = 0.
  - Outputs: locked = 0, err = 0, err_count = 0, lost_count = 0, zero_flag = 0.
  - Reset overrides enable and clear.
  - Reset mid-CHECK discards all history and forces a full re-seed.
- History: LEN-bit shift register. On every enable cycle the received rxBit shifts in, in every state; predicted bits are never inserted.
- Prediction: pred = hist[oldest] ^ hist[LEN-1-TAP positions back], evaluated from the history before the shift.
- State SEED:
  - Each enable increments the seed counter, with no comparison and err = 0.
  - When the LEN-th bit is accepted, the counter clears and the state moves to CHECK on that edge.
  - locked = 1 from the next cycle.
  - The first compared bit is bit LEN+1.
- State CHECK: on each enable, mismatch = rxBit ^ pred.
  - Mismatch:
    - err = 1 for exactly the next cycle.
    - err_count += 1, saturating at all ones.
    - Consecutive counter += 1.
  - Match: consecutive counter = 0, err = 0.
  - When the consecutive counter reaches LOSS_THRESH on a mismatch:
    - Go to SEED on that same edge.
    - locked = 0 next cycle.
    - lost_count += 1, saturating.
    - Consecutive counter and seed counter = 0.
    - That bit still counts in err_count.
- enable==0: all state, counters and history hold; err = 0.
- Latency: err and err_count reflect bit n one cycle after the edge that samples it.
- clear:
  - Zeroes err_count and lost_count; does not affect state, history or locked.
  - If clear coincides with an error or a lock loss, clear wins: the counts read 0 next cycle, and err still pulses.
- Error propagation: one flipped bit in CHECK yields exactly 3 mismatches, at n, n+(LEN-TAP) and n+LEN (n, n+1, n+127 by default).
- All-zero stream: a generator released from reset emits all zeros. This is a valid sequence: the checker locks and reports no errors unless zero_flag is built in.

Optional Feature:
- Macro PRBS_CHECK_ZERO_DET_EN.
- When defined:
  - zero_flag is registered, set when locked == 1 and history == 0 after an enable shift.
  - Cleared when a 1 is received, or by reset or lock loss.
  - Does not alter err or the counters.
- When undefined: no detect logic; zero_flag is constant 0.

Test Plan:
- Seeded clean stream: reset, then 1000 enabled bits from a reference generator loaded with 127'h1 -> locked rises after bit 127; err never pulses; err_count = 0, lost_count = 0.
- Single-bit flip: invert bit 500 of the stream -> exactly 3 err pulses (bits 500, 501, 627); err_count = 3; locked stays 1.
- Loss of lock: after lock, feed 8 bits each inverted from the prediction -> err_count = 8, lost_count = 1, locked = 0; 127 clean bits later locked = 1 again.
- Gapped enable with clear: toggle enable randomly during a clean stream -> no errors. Assert clear on the same cycle as an injected error -> err pulses, err_count reads 0.
- Saturation: ERR_W = 4, continuous random data with LOSS_THRESH = 255 -> err_count stops at 15 and does not wrap.
- Reset mid-CHECK, plus zero detect: drop reset for one cycle while locked -> all outputs 0 and 127 bits are needed to relock. With PRBS_CHECK_ZERO_DET_EN, 127 zeros -> locked = 1 and zero_flag = 1.
